// File: rtl/game_bg_pkg.sv
// rtl/game_bg_pkg.sv - shared types, colours and sizing helper for the background layer
package game_bg_pkg;

    typedef logic [7:0] rgb332_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FLASH_ON,
        FLASH_OFF
    } flash_state_t;

    localparam rgb332_t RGB_SKY0   = 8'hFC;
    localparam rgb332_t RGB_SKY1   = 8'hF8;
    localparam rgb332_t RGB_SKY2   = 8'hF4;
    localparam rgb332_t RGB_SKY3   = 8'hF0;
    localparam rgb332_t RGB_GROUND = 8'hF0;
    localparam rgb332_t RGB_WHITE  = 8'hFF;
    localparam rgb332_t RGB_BLACK  = 8'h00;

    // Bits needed to hold the values 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bg_wave_gen.sv
// rtl/bg_wave_gen.sv - frame divider driving a triangle-shaped horizon offset
module bg_wave_gen
    import game_bg_pkg::*;
#(
    parameter int  WAVE_AMPL = 4,
    parameter int  FRAME_DIV = 8,
    localparam int OFS_W     = cnt_width(WAVE_AMPL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    output logic [OFS_W-1:0] waveOfs
);

    localparam int FD_W = cnt_width(FRAME_DIV);

    logic [FD_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [OFS_W-1:0] wave_ofs_q, wave_ofs_d;
    logic             wave_down_q, wave_down_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        wave_ofs_d  = wave_ofs_q;
        wave_down_d = wave_down_q;
        if (startOfFrame) begin
            if (frame_cnt_q == FD_W'(FRAME_DIV - 1)) begin
                frame_cnt_d = '0;
                // Direction flips on the step that lands on an end point.
                if (WAVE_AMPL > 0) begin
                    if (wave_down_q) begin
                        wave_ofs_d = wave_ofs_q - OFS_W'(1);
                        if (wave_ofs_q == OFS_W'(1)) begin
                            wave_down_d = 1'b0;
                        end
                    end else begin
                        wave_ofs_d = wave_ofs_q + OFS_W'(1);
                        if (wave_ofs_q == OFS_W'(WAVE_AMPL - 1)) begin
                            wave_down_d = 1'b1;
                        end
                    end
                end
            end else begin
                frame_cnt_d = frame_cnt_q + FD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            wave_ofs_q  <= '0;
            wave_down_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            wave_ofs_q  <= wave_ofs_d;
            wave_down_q <= wave_down_d;
        end
    end

    assign waveOfs = wave_ofs_q;

endmodule

// File: rtl/game_background_bitmap.sv
// rtl/game_background_bitmap.sv - sky gradient over a bobbing horizon with frame flash effect
module game_background_bitmap
    import game_bg_pkg::*;
#(
    parameter int                    COORD_W      = 11,
    parameter int                    HORIZON_Y    = 80,
    parameter int                    NUM_SHADES   = 4,
    parameter int                    SHADE_SHIFT  = 5,
    parameter logic [NUM_SHADES*8-1:0] SKY_PALETTE = {RGB_SKY3, RGB_SKY2, RGB_SKY1, RGB_SKY0},
    parameter rgb332_t               GROUND_COLOR = RGB_GROUND,
    parameter int                    WAVE_AMPL    = 4,
    parameter int                    FRAME_DIV    = 8,
    parameter rgb332_t               FLASH_COLOR  = RGB_WHITE,
    parameter int                    FLASH_FRAMES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic [COORD_W-1:0] offsetX,
    input  logic [COORD_W-1:0] offsetY,
    input  logic               enable,
    input  logic               flashReq,
    output logic               drawingRequest,
    output logic [7:0]         RGBout,
    output logic               flashActive
);

    localparam int OFS_W = cnt_width(WAVE_AMPL);
    localparam int FC_W  = cnt_width(FLASH_FRAMES - 1);

    logic [OFS_W-1:0] wave_ofs;
    flash_state_t     state_q, state_d;
    logic [FC_W-1:0]  flash_cnt_q, flash_cnt_d;
    logic [COORD_W:0] horizon;
    logic [COORD_W-1:0] band;
    rgb332_t          sky_color, pix_color;
    rgb332_t          rgb_q, rgb_d;
    logic             draw_q, draw_d;
    logic             unused_offset_x;

    assign unused_offset_x = ^offsetX;

    bg_wave_gen #(
        .WAVE_AMPL (WAVE_AMPL),
        .FRAME_DIV (FRAME_DIV)
    ) u_wave (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .waveOfs      (wave_ofs)
    );

    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        case (state_q)
            IDLE: begin
                if (flashReq) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (startOfFrame) begin
                    state_d     = FLASH_ON;
                    flash_cnt_d = FC_W'(FLASH_FRAMES - 1);
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (startOfFrame) begin
                    if (flash_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        flash_cnt_d = flash_cnt_q - FC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // One extra bit so a horizon near the bottom of the coordinate range cannot wrap.
    assign horizon = (COORD_W + 1)'(HORIZON_Y) + (COORD_W + 1)'(wave_ofs);
    assign band    = offsetY >> SHADE_SHIFT;

    always_comb begin
        sky_color = SKY_PALETTE[(NUM_SHADES-1)*8 +: 8];
        for (int i = 0; i < NUM_SHADES - 1; i++) begin
            if (band == COORD_W'(i)) begin
                sky_color = SKY_PALETTE[i*8 +: 8];
            end
        end
    end

    always_comb begin
        pix_color = GROUND_COLOR;
        if (state_q == FLASH_ON) begin
            pix_color = FLASH_COLOR;
        end else if ({1'b0, offsetY} < horizon) begin
            pix_color = sky_color;
        end
        draw_d = enable;
        rgb_d  = enable ? pix_color : RGB_BLACK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_q <= 1'b0;
            rgb_q  <= RGB_BLACK;
        end else begin
            draw_q <= draw_d;
            rgb_q  <= rgb_d;
        end
    end

    assign drawingRequest = draw_q;
    assign RGBout         = rgb_q;
    assign flashActive    = (state_q == FLASH_ON) || (state_q == FLASH_OFF);

endmodule
